// File: rtl/dkong3_video_timing_pkg.sv
// dkong3_video_pkg: shared timing defaults and helper functions for the
// Donkey Kong 3 video timing generator.
//   DEF_*      default raster geometry (pixels / lines, counted from 0)
//   in_window  circular half-open window test [s,e)
//   mod_add    position + signed offset folded back into [0,total)
package dkong3_video_pkg;

  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_H_TOTAL = 384;
  localparam int DEF_H_BL_S  = 256;
  localparam int DEF_H_BL_E  = 0;
  localparam int DEF_H_SY_S  = 288;
  localparam int DEF_H_SY_E  = 320;
  localparam int DEF_V_TOTAL = 264;
  localparam int DEF_V_BL_S  = 240;
  localparam int DEF_V_BL_E  = 16;
  localparam int DEF_V_SY_S  = 244;
  localparam int DEF_V_SY_E  = 248;
  localparam int DEF_OFS_W   = 5;

  // s<e: plain range; s>e: range wraps through 0; s==e: empty.
  function automatic logic in_window(input int c, input int s, input int e);
    if (s < e)      return (c >= s) && (c < e);
    else if (s > e) return (c >= s) || (c < e);
    else            return 1'b0;
  endfunction

  // Caller guarantees |ofs| < total, so one correction step is enough.
  function automatic int mod_add(input int pos, input int ofs, input int total);
    int sum;
    sum = pos + ofs;
    if (sum >= total)  sum = sum - total;
    else if (sum < 0)  sum = sum + total;
    return sum;
  endfunction

endpackage

// File: rtl/dkong3_axis_counter.sv
// dkong3_axis_counter: one raster axis (horizontal or vertical).
//   clk, rst_n    clock, async active-low reset
//   adv           advance the count this cycle
//   sample        load the offset shadow from ofs this cycle
//   ofs           signed sync shift
//   cnt           current position
//   wrap          combinational: advancing out of TOTAL-1 this cycle
//   blank_n       registered active-low blank, aligned with cnt
//   blank_n_next  value blank_n takes at the next edge
//   sync_n        registered active-low sync (offset applied), aligned with cnt
module dkong3_axis_counter
  import dkong3_video_pkg::*;
#(
  parameter int TOTAL = DEF_H_TOTAL,
  parameter int BL_S  = DEF_H_BL_S,
  parameter int BL_E  = DEF_H_BL_E,
  parameter int SY_S  = DEF_H_SY_S,
  parameter int SY_E  = DEF_H_SY_E,
  parameter int OFS_W = DEF_OFS_W,
  parameter int W     = $clog2(TOTAL)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    adv,
  input  logic                    sample,
  input  logic signed [OFS_W-1:0] ofs,
  output logic [W-1:0]            cnt,
  output logic                    wrap,
  output logic                    blank_n,
  output logic                    blank_n_next,
  output logic                    sync_n
);

  if (BL_S < 0 || BL_S >= TOTAL || BL_E < 0 || BL_E >= TOTAL ||
      SY_S < 0 || SY_S >= TOTAL || SY_E < 0 || SY_E >= TOTAL) begin : g_bad_pos
    $error("dkong3_axis_counter: window position outside 0..TOTAL-1");
  end
  if ((1 << (OFS_W - 1)) >= TOTAL) begin : g_bad_ofs
    $error("dkong3_axis_counter: offset range must stay below TOTAL");
  end

  localparam logic [W-1:0] LAST        = W'(TOTAL - 1);
  localparam logic         BLANK_N_RST = !in_window(0, BL_S, BL_E);
  localparam logic         SYNC_N_RST  = !in_window(0, SY_S, SY_E);

  logic [W-1:0]            cnt_next;
  logic signed [OFS_W-1:0] shadow;
  logic signed [OFS_W-1:0] shadow_next;
  logic                    sync_n_next;
  int                      sy_s_eff;
  int                      sy_e_eff;

  // Flags decode the next count with the next shadow, so the registered
  // flag lines up with the registered count in the same cycle.
  always_comb begin
    wrap        = adv && (cnt == LAST);
    cnt_next    = cnt;
    if (adv) cnt_next = wrap ? '0 : cnt + 1'b1;
    shadow_next = sample ? ofs : shadow;
    sy_s_eff    = mod_add(SY_S, int'(shadow_next), TOTAL);
    sy_e_eff    = mod_add(SY_E, int'(shadow_next), TOTAL);
    blank_n_next = !in_window(int'(cnt_next), BL_S, BL_E);
    sync_n_next  = !in_window(int'(cnt_next), sy_s_eff, sy_e_eff);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      shadow  <= '0;
      blank_n <= BLANK_N_RST;
      sync_n  <= SYNC_N_RST;
    end else begin
      cnt     <= cnt_next;
      shadow  <= shadow_next;
      blank_n <= blank_n_next;
      sync_n  <= sync_n_next;
    end
  end

endmodule

// File: rtl/dkong3_video_timing.sv
// dkong3_video_timing: raster timing generator.
//   I_CLK, I_RST_n            master clock, async active-low reset
//   I_HFLIP, I_VFLIP          invert counts on O_HF_CNT / O_VF_CNT
//   I_H_OFFSET, I_V_OFFSET    signed sync shifts, taken once per frame
//   O_PIX_CE                  one-I_CLK pixel enable every CLK_DIV cycles
//   O_H_CNT, O_V_CNT          pixel / line counts
//   O_HF_CNT, O_VF_CNT        flip-adjusted counts
//   O_H/V/C_BLANKn            active-low blanks
//   O_H/V_SYNCn               active-low syncs
//   O_LINE_START/FRAME_START  one-cycle pulses on H (and V) returning to 0
//   O_FIELD                   frame parity
module dkong3_video_timing
  import dkong3_video_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int H_TOTAL = DEF_H_TOTAL,
  parameter int H_BL_S  = DEF_H_BL_S,
  parameter int H_BL_E  = DEF_H_BL_E,
  parameter int H_SY_S  = DEF_H_SY_S,
  parameter int H_SY_E  = DEF_H_SY_E,
  parameter int V_TOTAL = DEF_V_TOTAL,
  parameter int V_BL_S  = DEF_V_BL_S,
  parameter int V_BL_E  = DEF_V_BL_E,
  parameter int V_SY_S  = DEF_V_SY_S,
  parameter int V_SY_E  = DEF_V_SY_E,
  parameter int OFS_W   = DEF_OFS_W,
  localparam int HW     = $clog2(H_TOTAL),
  localparam int VW     = $clog2(V_TOTAL)
) (
  input  logic                    I_CLK,
  input  logic                    I_RST_n,
  input  logic                    I_HFLIP,
  input  logic                    I_VFLIP,
  input  logic signed [OFS_W-1:0] I_H_OFFSET,
  input  logic signed [OFS_W-1:0] I_V_OFFSET,
  output logic                    O_PIX_CE,
  output logic [HW-1:0]           O_H_CNT,
  output logic [VW-1:0]           O_V_CNT,
  output logic [HW-1:0]           O_HF_CNT,
  output logic [VW-1:0]           O_VF_CNT,
  output logic                    O_H_BLANKn,
  output logic                    O_V_BLANKn,
  output logic                    O_C_BLANKn,
  output logic                    O_H_SYNCn,
  output logic                    O_V_SYNCn,
  output logic                    O_LINE_START,
  output logic                    O_FRAME_START,
  output logic                    O_FIELD
);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("dkong3_video_timing: CLK_DIV must be at least 1");
  end

  localparam int             PW          = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST    = PW'(CLK_DIV - 1);
  localparam logic           C_BLANK_RST = !in_window(0, H_BL_S, H_BL_E) &&
                                           !in_window(0, V_BL_S, V_BL_E);

  logic [PW-1:0] pre;
  logic [PW-1:0] pre_next;
  logic          h_wrap;
  logic          v_wrap;
  logic          h_blank_next;
  logic          v_blank_next;

  always_comb pre_next = (pre == PRE_LAST) ? '0 : pre + 1'b1;

  dkong3_axis_counter #(
    .TOTAL(H_TOTAL), .BL_S(H_BL_S), .BL_E(H_BL_E),
    .SY_S(H_SY_S), .SY_E(H_SY_E), .OFS_W(OFS_W), .W(HW)
  ) u_h_axis (
    .clk(I_CLK), .rst_n(I_RST_n), .adv(O_PIX_CE), .sample(O_FRAME_START),
    .ofs(I_H_OFFSET), .cnt(O_H_CNT), .wrap(h_wrap), .blank_n(O_H_BLANKn),
    .blank_n_next(h_blank_next), .sync_n(O_H_SYNCn)
  );

  dkong3_axis_counter #(
    .TOTAL(V_TOTAL), .BL_S(V_BL_S), .BL_E(V_BL_E),
    .SY_S(V_SY_S), .SY_E(V_SY_E), .OFS_W(OFS_W), .W(VW)
  ) u_v_axis (
    .clk(I_CLK), .rst_n(I_RST_n), .adv(h_wrap), .sample(O_FRAME_START),
    .ofs(I_V_OFFSET), .cnt(O_V_CNT), .wrap(v_wrap), .blank_n(O_V_BLANKn),
    .blank_n_next(v_blank_next), .sync_n(O_V_SYNCn)
  );

  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n) begin
      pre           <= '0;
      O_PIX_CE      <= 1'b0;
      O_LINE_START  <= 1'b0;
      O_FRAME_START <= 1'b0;
      O_FIELD       <= 1'b0;
      O_C_BLANKn    <= C_BLANK_RST;
    end else begin
      pre           <= pre_next;
      O_PIX_CE      <= (pre_next == PRE_LAST);
      O_LINE_START  <= h_wrap;
      O_FRAME_START <= v_wrap;
      O_FIELD       <= O_FIELD ^ v_wrap;
      O_C_BLANKn    <= h_blank_next & v_blank_next;
    end
  end

  assign O_HF_CNT = O_H_CNT ^ {HW{I_HFLIP}};
  assign O_VF_CNT = O_V_CNT ^ {VW{I_VFLIP}};

endmodule

// File: tb/tb_dkong3_video_timing.sv
// Bench for dkong3_video_timing: a default-geometry instance and a small
// fast-framing instance share randomized flip/offset stimulus and reset.
module tb_dkong3_video_timing;

  typedef struct packed {
    int d; int ht; int hbs; int hbe; int hss; int hse;
    int vt; int vbs; int vbe; int vss; int vse; int hw; int vw;
  } tp_t;

  typedef struct packed {
    int pix_ce; int h; int v; int hf; int vf; int hb; int vb; int cb;
    int hs; int vs; int ls; int fs; int field;
  } ex_t;

  localparam tp_t P_DEF = '{d:4, ht:384, hbs:256, hbe:0, hss:288, hse:320,
                            vt:264, vbs:240, vbe:16, vss:244, vse:248, hw:9, vw:9};
  localparam tp_t P_SM  = '{d:2, ht:40, hbs:30, hbe:2, hss:33, hse:36,
                            vt:20, vbs:17, vbe:17, vss:18, vse:1, hw:6, vw:5};

  logic clk = 1'b0;
  logic rst_n;
  logic hflip, vflip;
  logic signed [4:0] hoff, voff;

  logic       d_ce, d_hb, d_vb, d_cb, d_hs, d_vs, d_ls, d_fs, d_field;
  logic [8:0] d_h, d_hf;
  logic [8:0] d_v, d_vf;
  logic       s_ce, s_hb, s_vb, s_cb, s_hs, s_vs, s_ls, s_fs, s_field;
  logic [5:0] s_h, s_hf;
  logic [4:0] s_v, s_vf;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int shx_d = 0, shy_d = 0, shx_s = 0, shy_s = 0;

  always #5 clk = ~clk;

  dkong3_video_timing u_def (
    .I_CLK(clk), .I_RST_n(rst_n), .I_HFLIP(hflip), .I_VFLIP(vflip),
    .I_H_OFFSET(hoff), .I_V_OFFSET(voff), .O_PIX_CE(d_ce),
    .O_H_CNT(d_h), .O_V_CNT(d_v), .O_HF_CNT(d_hf), .O_VF_CNT(d_vf),
    .O_H_BLANKn(d_hb), .O_V_BLANKn(d_vb), .O_C_BLANKn(d_cb),
    .O_H_SYNCn(d_hs), .O_V_SYNCn(d_vs), .O_LINE_START(d_ls),
    .O_FRAME_START(d_fs), .O_FIELD(d_field)
  );

  dkong3_video_timing #(
    .CLK_DIV(2), .H_TOTAL(40), .H_BL_S(30), .H_BL_E(2), .H_SY_S(33), .H_SY_E(36),
    .V_TOTAL(20), .V_BL_S(17), .V_BL_E(17), .V_SY_S(18), .V_SY_E(1), .OFS_W(5)
  ) u_sm (
    .I_CLK(clk), .I_RST_n(rst_n), .I_HFLIP(hflip), .I_VFLIP(vflip),
    .I_H_OFFSET(hoff), .I_V_OFFSET(voff), .O_PIX_CE(s_ce),
    .O_H_CNT(s_h), .O_V_CNT(s_v), .O_HF_CNT(s_hf), .O_VF_CNT(s_vf),
    .O_H_BLANKn(s_hb), .O_V_BLANKn(s_vb), .O_C_BLANKn(s_cb),
    .O_H_SYNCn(s_hs), .O_V_SYNCn(s_vs), .O_LINE_START(s_ls),
    .O_FRAME_START(s_fs), .O_FIELD(s_field)
  );

  function automatic int wmod(int a, int t);
    int r;
    r = a % t;
    if (r < 0) r = r + t;
    return r;
  endfunction

  // Walk the window from s towards e around the circle.
  function automatic int covers(int c, int s, int e, int t);
    for (int k = s; k != e; k = (k + 1) % t)
      if (k == c) return 1;
    return 0;
  endfunction

  // Output state n clock edges after reset release (valid for d >= 2).
  function automatic ex_t model(tp_t p, int n, int shx, int shy, int hfl, int vfl);
    ex_t r;
    int pix, line;
    r = '0;
    pix     = n / p.d;
    line    = pix / p.ht;
    r.h     = pix % p.ht;
    r.v     = line % p.vt;
    r.field = (line / p.vt) % 2;
    r.pix_ce = int'(n % p.d == p.d - 1);
    r.ls    = int'(n > 0 && n % (p.d * p.ht) == 0);
    r.fs    = int'(n > 0 && n % (p.d * p.ht * p.vt) == 0);
    r.hb    = 1 - covers(r.h, p.hbs, p.hbe, p.ht);
    r.vb    = 1 - covers(r.v, p.vbs, p.vbe, p.vt);
    r.cb    = r.hb & r.vb;
    r.hs    = 1 - covers(r.h, wmod(p.hss + shx, p.ht), wmod(p.hse + shx, p.ht), p.ht);
    r.vs    = 1 - covers(r.v, wmod(p.vss + shy, p.vt), wmod(p.vse + shy, p.vt), p.vt);
    r.hf    = (hfl != 0) ? (((1 << p.hw) - 1) ^ r.h) : r.h;
    r.vf    = (vfl != 0) ? (((1 << p.vw) - 1) ^ r.v) : r.v;
    return r;
  endfunction

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp)
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    else
      n_pass++;
  endtask

  task automatic cmp_all(string tag, ex_t a, ex_t e);
    check({tag, ".pix_ce"}, a.pix_ce, e.pix_ce);
    check({tag, ".h_cnt"}, a.h, e.h);
    check({tag, ".v_cnt"}, a.v, e.v);
    check({tag, ".hf_cnt"}, a.hf, e.hf);
    check({tag, ".vf_cnt"}, a.vf, e.vf);
    check({tag, ".h_blank_n"}, a.hb, e.hb);
    check({tag, ".v_blank_n"}, a.vb, e.vb);
    check({tag, ".c_blank_n"}, a.cb, e.cb);
    check({tag, ".h_sync_n"}, a.hs, e.hs);
    check({tag, ".v_sync_n"}, a.vs, e.vs);
    check({tag, ".line_start"}, a.ls, e.ls);
    check({tag, ".frame_start"}, a.fs, e.fs);
    check({tag, ".field"}, a.field, e.field);
  endtask

  function automatic ex_t grab_def();
    ex_t a;
    a = '{pix_ce:int'(d_ce), h:int'(d_h), v:int'(d_v), hf:int'(d_hf), vf:int'(d_vf),
          hb:int'(d_hb), vb:int'(d_vb), cb:int'(d_cb), hs:int'(d_hs), vs:int'(d_vs),
          ls:int'(d_ls), fs:int'(d_fs), field:int'(d_field)};
    return a;
  endfunction

  function automatic ex_t grab_sm();
    ex_t a;
    a = '{pix_ce:int'(s_ce), h:int'(s_h), v:int'(s_v), hf:int'(s_hf), vf:int'(s_vf),
          hb:int'(s_hb), vb:int'(s_vb), cb:int'(s_cb), hs:int'(s_hs), vs:int'(s_vs),
          ls:int'(s_ls), fs:int'(s_fs), field:int'(s_field)};
    return a;
  endfunction

  // Compare process: every cycle, both instances against the model.
  always @(negedge clk) begin
    ex_t ad, as_, ed, es;
    if (!rst_n) begin
      cyc = 0; shx_d = 0; shy_d = 0; shx_s = 0; shy_s = 0;
    end
    ad  = grab_def();
    as_ = grab_sm();
    ed  = model(P_DEF, cyc, shx_d, shy_d, int'(hflip), int'(vflip));
    es  = model(P_SM,  cyc, shx_s, shy_s, int'(hflip), int'(vflip));
    cmp_all("def", ad, ed);
    cmp_all("sm", as_, es);
    if (rst_n) begin
      // Hand-computed anchors for the default geometry.
      if (cyc == 3)     check("lit.pix_ce_first", int'(d_ce), 1);
      if (cyc == 4)     check("lit.h_after_ce", int'(d_h), 1);
      if (cyc == 20)    check("lit.hflip_h5", int'(d_hf), 506);
      if (cyc == 1023)  check("lit.hblank_h255", int'(d_hb), 1);
      if (cyc == 1024)  check("lit.hblank_h256", int'(d_hb), 0);
      if (cyc == 1024)  check("lit.cblank_h256", int'(d_cb), 0);
      if (cyc == 1151)  check("lit.hsync_h287", int'(d_hs), 1);
      if (cyc == 1152)  check("lit.hsync_h288", int'(d_hs), 0);
      if (cyc == 1279)  check("lit.hsync_h319", int'(d_hs), 0);
      if (cyc == 1280)  check("lit.hsync_h320", int'(d_hs), 1);
      if (cyc == 1536)  check("lit.line_start", int'(d_ls), 1);
      if (cyc == 1536)  check("lit.v_line1", int'(d_v), 1);
      if (cyc == 1537)  check("lit.line_start_end", int'(d_ls), 0);
      if (cyc == 24576) check("lit.vflip_v16", int'(d_vf), 495);
      if (cyc == 24576) check("lit.vblank_v16", int'(d_vb), 1);
      if (cyc == 1600)  check("lit.sm_frame_start", int'(s_fs), 1);
      if (cyc == 1600)  check("lit.sm_field", int'(s_field), 1);
      // Shadows take the inputs present during the frame-start cycle.
      if (ed.fs != 0) begin shx_d = int'(hoff); shy_d = int'(voff); end
      if (es.fs != 0) begin shx_s = int'(hoff); shy_s = int'(voff); end
      cyc++;
    end
  end

  task automatic run(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      hflip = 1'($urandom_range(0, 1));
      vflip = 1'($urandom_range(0, 1));
      if (cyc == 20)    hflip = 1'b1;
      if (cyc == 24576) vflip = 1'b1;
      if ($urandom_range(0, 39) == 0) hoff = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 39) == 0) voff = 5'($urandom_range(0, 31));
    end
  endtask

  // Reset forced between clock edges must show its values at once.
  task automatic async_reset_check();
    ex_t es;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst.h_cnt", int'(d_h), 0);
    check("rst.v_cnt", int'(d_v), 0);
    check("rst.pix_ce", int'(d_ce), 0);
    check("rst.h_blank_n", int'(d_hb), 1);
    check("rst.v_blank_n", int'(d_vb), 0);
    check("rst.c_blank_n", int'(d_cb), 0);
    check("rst.h_sync_n", int'(d_hs), 1);
    check("rst.v_sync_n", int'(d_vs), 1);
    check("rst.line_start", int'(d_ls), 0);
    check("rst.frame_start", int'(d_fs), 0);
    check("rst.field", int'(d_field), 0);
    es = model(P_SM, 0, 0, 0, int'(hflip), int'(vflip));
    cmp_all("rst_sm", grab_sm(), es);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    hflip = 1'b0;
    vflip = 1'b0;
    hoff  = '0;
    voff  = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run(26000);
    for (int r = 0; r < 3; r++) begin
      async_reset_check();
      run(int'($urandom_range(2000, 4000)));
    end
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
